// File: rtl/y86_pkg.sv
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared Y-86 constants: instruction codes, the fetch-state
//                encoding and the program-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package y86_pkg;

    // Program-counter / data word width
    localparam int PC_W = 64;

    // Instruction codes
    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Fetch-state encoding (visible on the f_state port)
    typedef enum logic [1:0] {
        FS_RUN      = 2'd0,
        FS_RET_WAIT = 2'd1,
        FS_HALT     = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/fetch_pc_predict.sv
// ============================================================================
//  Module      : fetch_pc_predict
//  Description : Combinational next-PC prediction. Jumps and calls predict
//                their constant target; everything else (including ret, halt
//                and illegal icodes) predicts the sequential successor.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_predict
    import y86_pkg::*;
(
    input  logic [3:0]      f_icode,
    input  logic [PC_W-1:0] f_valC,
    input  logic [PC_W-1:0] f_valP,
    output logic [PC_W-1:0] pred
);

    // Taken-branch / call target versus fall-through
    always_comb begin
        pred = f_valP;
        if ((f_icode == I_JXX) || (f_icode == I_CALL)) begin
            pred = f_valC;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_pc_select.sv
// ============================================================================
//  Module      : fetch_pc_select
//  Description : F-stage PC generator for the pipelined Y-86 core. Holds the
//                predicted-PC register, selects the fetch address from the
//                prediction / M-stage mispredict / W-stage ret redirects and
//                bubbles fetch while a ret is unresolved or after halt.
//                Optional build macro FETCH_PERF_EN adds saturating
//                performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_pc_select
    import y86_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 64'h0
`ifdef FETCH_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            F_stall,
    input  logic [3:0]      f_icode,
    input  logic [PC_W-1:0] f_valC,
    input  logic [PC_W-1:0] f_valP,
    input  logic [3:0]      M_icode,
    input  logic            M_cnd,
    input  logic [PC_W-1:0] M_valA,
    input  logic [3:0]      W_icode,
    input  logic [PC_W-1:0] W_valM,
    output logic [PC_W-1:0] f_pc,
    output logic [PC_W-1:0] F_predPC,
    output logic            f_valid,
    output logic [1:0]      f_state
`ifdef FETCH_PERF_EN
    ,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] ret_bubble_cnt,
    output logic [CNT_W-1:0] halt_cycles
`endif
);

    logic [PC_W-1:0] r_pred_pc;
    logic [PC_W-1:0] w_pred;
    logic            w_mispred;
    logic            w_wret;
    fetch_state_t    r_state;
    fetch_state_t    w_next_state;

    assign w_mispred = (M_icode == I_JXX) && !M_cnd;
    assign w_wret    = (W_icode == I_RET);

    fetch_pc_predict u_predict (
        .f_icode (f_icode),
        .f_valC  (f_valC),
        .f_valP  (f_valP),
        .pred    (w_pred)
    );

    // Fetch-address select (mispredict beats ret) and fetch validity by state
    always_comb begin
        f_pc = r_pred_pc;
        if (w_mispred) begin
            f_pc = M_valA;
        end else if (w_wret) begin
            f_pc = W_valM;
        end

        f_valid = 1'b1;
        case (r_state)
            FS_RUN:      f_valid = 1'b1;
            FS_RET_WAIT: f_valid = w_mispred || w_wret;
            FS_HALT:     f_valid = w_mispred;
            default:     f_valid = 1'b1;
        endcase
    end

    // Next state follows the icode of a valid fetch; a bubble holds state
    always_comb begin
        w_next_state = r_state;
        if (f_valid) begin
            if (f_icode == I_RET) begin
                w_next_state = FS_RET_WAIT;
            end else if (f_icode == I_HALT) begin
                w_next_state = FS_HALT;
            end else begin
                w_next_state = FS_RUN;
            end
        end
    end

    // Predicted-PC register and state; both hold on stall or bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_pc <= RESET_PC;
            r_state   <= FS_RUN;
        end else if (!F_stall) begin
            r_state <= w_next_state;
            if (f_valid) begin
                r_pred_pc <= w_pred;
            end
        end
    end

    assign F_predPC = r_pred_pc;
    assign f_state  = r_state;

`ifdef FETCH_PERF_EN
    logic [CNT_W-1:0] r_mispred_cnt;
    logic [CNT_W-1:0] r_ret_bubble_cnt;
    logic [CNT_W-1:0] r_halt_cycles;

    // Saturating event counters, advanced only on non-stalled cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mispred_cnt    <= '0;
            r_ret_bubble_cnt <= '0;
            r_halt_cycles    <= '0;
        end else if (!F_stall) begin
            if (w_mispred && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
            end
            if ((r_state == FS_RET_WAIT) && !f_valid && (r_ret_bubble_cnt != '1)) begin
                r_ret_bubble_cnt <= r_ret_bubble_cnt + 1'b1;
            end
            if ((r_state == FS_HALT) && !f_valid && (r_halt_cycles != '1)) begin
                r_halt_cycles <= r_halt_cycles + 1'b1;
            end
        end
    end

    assign mispred_cnt    = r_mispred_cnt;
    assign ret_bubble_cnt = r_ret_bubble_cnt;
    assign halt_cycles    = r_halt_cycles;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_pc_select.sv
// ============================================================================
//  Module      : tb_fetch_pc_select
//  Description : Self-checking bench for fetch_pc_select: directed scenarios
//                plus a randomized run against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_pc_select;

    localparam logic [63:0] C_RESET_PC = 64'h100;

    logic        clk;
    logic        rst;
    logic        F_stall;
    logic [3:0]  f_icode;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic [3:0]  M_icode;
    logic        M_cnd;
    logic [63:0] M_valA;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic [63:0] f_pc;
    logic [63:0] F_predPC;
    logic        f_valid;
    logic [1:0]  f_state;

    int checks = 0;
    int errors = 0;

    fetch_pc_select #(.RESET_PC(C_RESET_PC)) dut (
        .clk      (clk),
        .rst      (rst),
        .F_stall  (F_stall),
        .f_icode  (f_icode),
        .f_valC   (f_valC),
        .f_valP   (f_valP),
        .M_icode  (M_icode),
        .M_cnd    (M_cnd),
        .M_valA   (M_valA),
        .W_icode  (W_icode),
        .W_valM   (W_valM),
        .f_pc     (f_pc),
        .F_predPC (F_predPC),
        .f_valid  (f_valid),
        .f_state  (f_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wait for the active edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_redirects();
        M_icode = 4'h1; M_cnd = 1'b1; M_valA = 64'h0;
        W_icode = 4'h1; W_valM = 64'h0;
    endtask

    task automatic fetch(input logic [3:0] ic, input logic [63:0] vc, input logic [63:0] vp);
        f_icode = ic; f_valC = vc; f_valP = vp;
    endtask

    task automatic test_reset();
        rst = 1'b1; F_stall = 1'b0;
        idle_redirects();
        fetch(4'h1, 64'h0, 64'h0);
        tick(); tick();
        @(negedge clk);
        rst = 1'b0;
        fetch(4'h7, 64'h200, 64'h109);
        #1;
        checks++; if (f_pc !== 64'h100) begin errors++; $display("FAIL reset_fpc got %h want %h", f_pc, 64'h100); end
        checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got %b want 1", f_valid); end
        checks++; if (f_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", f_state); end
        checks++; if (F_predPC !== 64'h100) begin errors++; $display("FAIL reset_predpc got %h want %h", F_predPC, 64'h100); end
    endtask

    task automatic test_mispredict();
        // jXX at 0x100 is being fetched (set up by test_reset)
        tick();
        checks++; if (F_predPC !== 64'h200) begin errors++; $display("FAIL jxx_pred got %h want %h", F_predPC, 64'h200); end
        @(negedge clk); fetch(4'h1, 64'h0, 64'h20a);
        tick();
        @(negedge clk);
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h109;
        fetch(4'h1, 64'h0, 64'h10a);
        #1;
        checks++; if (f_pc !== 64'h109) begin errors++; $display("FAIL mispred_fpc got %h want %h", f_pc, 64'h109); end
        checks++; if (f_valid !== 1'b1) begin errors++; $display("FAIL mispred_valid got %b want 1", f_valid); end
        tick();
        checks++; if (F_predPC !== 64'h10a) begin errors++; $display("FAIL mispred_pred got %h want %h", F_predPC, 64'h10a); end
        // Taken jump in M (M_cnd=1) is not a redirect
        @(negedge clk);
        M_cnd = 1'b1; M_valA = 64'hdead;
        #1;
        checks++; if (f_pc !== 64'h10a) begin errors++; $display("FAIL taken_no_redirect got %h want %h", f_pc, 64'h10a); end
        idle_redirects();
    endtask

    task automatic test_ret();
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h300;
        fetch(4'h9, 64'h0, 64'h301);
        #1;
        checks++; if (f_pc !== 64'h300) begin errors++; $display("FAIL ret_fpc got %h want %h", f_pc, 64'h300); end
        tick();
        checks++; if (f_state !== 2'd1) begin errors++; $display("FAIL ret_state got %0d want 1", f_state); end
        @(negedge clk); idle_redirects(); fetch(4'h1, 64'h0, 64'h555);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL retwait_valid cyc %0d got %b want 0", i, f_valid); end
            tick();
            checks++; if ((F_predPC !== 64'h301) || (f_state !== 2'd1)) begin errors++; $display("FAIL retwait_hold cyc %0d got %h/%0d want 301/1", i, F_predPC, f_state); end
            @(negedge clk);
        end
        W_icode = 4'h9; W_valM = 64'h420; fetch(4'h1, 64'h0, 64'h42a);
        #1;
        checks++; if ((f_pc !== 64'h420) || (f_valid !== 1'b1)) begin errors++; $display("FAIL wret_fpc got %h/%b want 420/1", f_pc, f_valid); end
        tick();
        checks++; if ((f_state !== 2'd0) || (F_predPC !== 64'h42a)) begin errors++; $display("FAIL wret_exit got %0d/%h want 0/42a", f_state, F_predPC); end
        idle_redirects();
    endtask

    task automatic test_halt();
        @(negedge clk); fetch(4'h0, 64'h0, 64'h42b);
        tick();
        checks++; if (f_state !== 2'd2) begin errors++; $display("FAIL halt_state got %0d want 2", f_state); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            fetch(4'h1, 64'h0, 64'(i * 16));
            W_icode = (i % 2 == 0) ? 4'h9 : 4'h1;   // a W ret must not wake halt
            W_valM = 64'h999;
            #1;
            checks++; if (f_valid !== 1'b0) begin errors++; $display("FAIL halt_valid cyc %0d got %b want 0", i, f_valid); end
            tick();
            checks++; if ((F_predPC !== 64'h42b) || (f_state !== 2'd2)) begin errors++; $display("FAIL halt_hold cyc %0d got %h/%0d want 42b/2", i, F_predPC, f_state); end
        end
        @(negedge clk);
        idle_redirects();
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h50;
        fetch(4'h1, 64'h0, 64'h5a);
        #1;
        checks++; if ((f_pc !== 64'h50) || (f_valid !== 1'b1)) begin errors++; $display("FAIL halt_exit_fpc got %h/%b want 50/1", f_pc, f_valid); end
        tick();
        checks++; if ((f_state !== 2'd0) || (F_predPC !== 64'h5a)) begin errors++; $display("FAIL halt_exit got %0d/%h want 0/5a", f_state, F_predPC); end
        @(negedge clk); idle_redirects();
    endtask

    task automatic test_priority();
        fetch(4'h9, 64'h0, 64'h5b);
        tick();
        @(negedge clk);
        M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h80;
        W_icode = 4'h9; W_valM = 64'h90;
        fetch(4'h1, 64'h0, 64'h8a);
        #1;
        checks++; if ((f_pc !== 64'h80) || (f_valid !== 1'b1)) begin errors++; $display("FAIL prio_fpc got %h/%b want 80/1", f_pc, f_valid); end
        tick();
        checks++; if ((f_state !== 2'd0) || (F_predPC !== 64'h8a)) begin errors++; $display("FAIL prio_next got %0d/%h want 0/8a", f_state, F_predPC); end
        // ret fetched right at a W-ret redirect re-enters RET_WAIT
        @(negedge clk); idle_redirects(); fetch(4'h9, 64'h0, 64'h8b);
        tick();
        @(negedge clk); W_icode = 4'h9; W_valM = 64'ha0; fetch(4'h9, 64'h0, 64'ha1);
        tick();
        checks++; if ((f_state !== 2'd1) || (F_predPC !== 64'ha1)) begin errors++; $display("FAIL ret_reenter got %0d/%h want 1/a1", f_state, F_predPC); end
        @(negedge clk); W_valM = 64'hb0; fetch(4'h1, 64'h0, 64'hb1);
        tick();
        @(negedge clk); idle_redirects();
    endtask

    task automatic test_stall_reset();
        F_stall = 1'b1; fetch(4'h8, 64'h700, 64'hbb);
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (F_predPC !== 64'hb1) begin errors++; $display("FAIL stall_hold cyc %0d got %h want b1", i, F_predPC); end
            @(negedge clk);
        end
        F_stall = 1'b0;
        tick();
        checks++; if (F_predPC !== 64'h700) begin errors++; $display("FAIL stall_release got %h want 700", F_predPC); end
        @(negedge clk); fetch(4'h9, 64'h0, 64'h701);
        tick();
        @(negedge clk); rst = 1'b1; F_stall = 1'b1; M_icode = 4'h7; M_cnd = 1'b0; M_valA = 64'h77;
        tick();
        checks++; if ((F_predPC !== C_RESET_PC) || (f_state !== 2'd0)) begin errors++; $display("FAIL reset_midwait got %h/%0d want 100/0", F_predPC, f_state); end
        @(negedge clk); rst = 1'b0; F_stall = 1'b0; idle_redirects();
    endtask

    // Randomized run against a behavioural model of the fetch front end
    task automatic test_random();
        logic [63:0] m_pred;
        int          m_mode;   // 0 running, 1 awaiting ret, 2 halted
        logic        mis, wr, exp_v;
        logic [63:0] exp_pc;
        rst = 1'b1; tick();
        m_pred = C_RESET_PC; m_mode = 0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            rst     = ($urandom_range(0, 59) == 0);
            F_stall = ($urandom_range(0, 7) == 0);
            fetch(($urandom_range(0, 5) == 0) ? 4'h9 : ($urandom_range(0, 9) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                  {$urandom, $urandom}, {$urandom, $urandom});
            M_icode = ($urandom_range(0, 3) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
            M_cnd   = 1'($urandom);
            M_valA  = {$urandom, $urandom};
            W_icode = ($urandom_range(0, 3) == 0) ? 4'h9 : 4'($urandom_range(0, 15));
            W_valM  = {$urandom, $urandom};
            mis = (M_icode == 4'd7) && !M_cnd;
            wr  = (W_icode == 4'd9);
            exp_pc = mis ? M_valA : (wr ? W_valM : m_pred);
            exp_v  = (m_mode == 0) || (m_mode == 1 && (mis || wr)) || (m_mode == 2 && mis);
            #1;
            checks++; if ((f_pc !== exp_pc) || (f_valid !== exp_v)) begin errors++; $display("FAIL rand_comb n=%0d got %h/%b want %h/%b", n, f_pc, f_valid, exp_pc, exp_v); end
            if (rst) begin
                m_pred = C_RESET_PC; m_mode = 0;
            end else if (!F_stall && exp_v) begin
                m_pred = (f_icode == 4'd7 || f_icode == 4'd8) ? f_valC : f_valP;
                m_mode = (f_icode == 4'd9) ? 1 : (f_icode == 4'd0) ? 2 : 0;
            end
            tick();
            checks++; if ((F_predPC !== m_pred) || (int'(f_state) != m_mode)) begin errors++; $display("FAIL rand_reg n=%0d got %h/%0d want %h/%0d", n, F_predPC, f_state, m_pred, m_mode); end
        end
        @(negedge clk); rst = 1'b0; F_stall = 1'b0; idle_redirects();
    endtask

    initial begin
        test_reset();
        test_mispredict();
        test_ret();
        test_halt();
        test_priority();
        test_stall_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
